// File: rtl/ps2_arrow_receiver.sv
// PS/2 keyboard frame receiver with extended arrow-key make/break decoding.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: Readable only when an arrow level changes.
module ps2_arrow_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 25000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       Up,
  output logic       Down,
  output logic       Left,
  output logic       Right,
  output logic       Readable,
  output logic [7:0] ScanCode,
  output logic       ScanValid,
  output logic       FrameError
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   sync_clk;
  logic                   sync_data;
  logic                   fall;

  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   parity_q;
  logic [TW-1:0]          to_q;
  logic [7:0]             scan_code_q;
  logic                   scan_valid_q;
  logic                   frame_error_q;

  logic                   break_q;
  logic                   ext_q;
  logic [3:0]             arrows_q;
  logic                   readable_q;
  logic                   arrow_hit;
  logic [1:0]             arrow_idx;

  // NOTE: synchroniser flops reset to 1, the idle bus level, so leaving reset never fakes a falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2Clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2Data};
      clk_prev_q  <= sync_clk;
    end
  end

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~sync_clk;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      to_q          <= '0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (state_q == S_IDLE || fall) begin
        to_q <= '0;
      end else begin
        to_q <= to_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (fall && !sync_data) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (fall) begin
            shift_q   <= {sync_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (fall) begin
            parity_q <= sync_data;
            state_q  <= S_STOP;
          end
        end
        S_STOP: begin
          if (fall) begin
            if ((^{shift_q, parity_q}) && sync_data) begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // A fall in the timeout cycle keeps the frame alive, so only abort when no edge arrived.
      if (state_q != S_IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q       <= S_IDLE;
        shift_q       <= '0;
        to_q          <= '0;
        frame_error_q <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    arrow_hit = 1'b0;
    arrow_idx = 2'd0;
    case (scan_code_q)
      8'h75: begin arrow_hit = 1'b1; arrow_idx = 2'd0; end
      8'h72: begin arrow_hit = 1'b1; arrow_idx = 2'd1; end
      8'h6B: begin arrow_hit = 1'b1; arrow_idx = 2'd2; end
      8'h74: begin arrow_hit = 1'b1; arrow_idx = 2'd3; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
      arrows_q   <= '0;
      readable_q <= 1'b0;
    end else begin
      readable_q <= 1'b0;
      if (frame_error_q) begin
        break_q <= 1'b0;
        ext_q   <= 1'b0;
      end else if (scan_valid_q) begin
        case (scan_code_q)
          8'hF0: break_q <= 1'b1;
          8'hE0: ext_q   <= 1'b1;
          default: begin
            if (ext_q && arrow_hit) begin
              arrows_q[arrow_idx] <= ~break_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
              // The level changes exactly when the held value equals the break flag.
              readable_q <= (arrows_q[arrow_idx] == break_q);
`else
              readable_q <= 1'b1;
`endif
            end
            break_q <= 1'b0;
            ext_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Up         = arrows_q[0];
  assign Down       = arrows_q[1];
  assign Left       = arrows_q[2];
  assign Right      = arrows_q[3];
  assign Readable   = readable_q;
  assign ScanCode   = scan_code_q;
  assign ScanValid  = scan_valid_q;
  assign FrameError = frame_error_q;

endmodule

// File: doc/ps2_arrow_receiver.md
Name: ps2_arrow_receiver

Overview:
- Deserialises PS/2 keyboard frames (start, 8 data, odd parity, stop) from the keyboard's PS2Clk/PS2Data lines.
- Decodes the extended arrow-key make and break sequences into level-held Up/Down/Left/Right.
- Sits directly upstream of the InputDecoder on the PS/2 path and supplies the PU/PD/PL/PR/PReadable bundle.
- Also exports raw scancodes and frame errors for debug.

Parameters:
- TIMEOUT_CYCLES, 25000: CLK cycles without a PS2Clk falling edge before a partial frame is aborted (1 ms at 25 MHz).
- SYNC_STAGES, 2: synchroniser depth for PS2Clk and PS2Data; minimum 2.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- PS2Clk  in  1  keyboard clock, asynchronous, idle high
- PS2Data  in  1  keyboard data, asynchronous, idle high
- Up  out  1  1 while up-arrow held
- Down  out  1  1 while down-arrow held
- Left  out  1  1 while left-arrow held
- Right  out  1  1 while right-arrow held
- Readable  out  1  one-cycle pulse when an arrow make/break is applied
- ScanCode  out  8  last accepted byte; held until next accept
- ScanValid  out  1  one-cycle pulse: ScanCode updated
- FrameError  out  1  one-cycle pulse: parity, stop or timeout error

Behaviour:
- Reset values:
  - All outputs 0; FSM IDLE; bit counter 0; timeout counter 0; break_pending and ext_pending 0.
  - Synchroniser flops reset to 1 (idle bus) so no false edge is seen after reset.
- Edge detect: fall = prev_sync_clk & ~sync_clk. PS2Data is sampled from the synchronised data in the same cycle.
- FSM:
  - IDLE: on fall with data=0, go to DATA and clear the bit counter. On fall with data=1, stay in IDLE (glitch ignored).
  - DATA: on each fall, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, the frame is good iff XOR(8 data, parity)=1 and stop=1.
    - Good: ScanCode<=byte and ScanValid pulses the next cycle.
    - Bad: FrameError pulses instead.
    - Either way, return to IDLE.
- Timeout:
  - The counter clears on every fall and whenever in IDLE; otherwise it increments.
  - When it reaches TIMEOUT_CYCLES-1: pulse FrameError, go to IDLE, discard the partial byte, clear both pending flags.
  - If a fall occurs in the same cycle as the timeout, the fall wins: the counter clears and no error is raised.
- Decoder, acting on each ScanValid byte:
  - F0 sets break_pending.
  - E0 sets ext_pending.
  - Any other byte:
    - If ext_pending is set and the byte is 75/72/6B/74, the matching Up/Down/Left/Right <= ~break_pending and Readable pulses.
    - Then both pending flags clear.
  - Non-extended 75/72/6B/74 (keypad codes) are ignored.
  - FrameError clears both pending flags.
- Latency:
  - Stop-bit fall detected in cycle N: ScanValid/ScanCode in N+1; arrow outputs and Readable in N+2.
  - PS2 pin-to-fall delay is SYNC_STAGES+1 cycles.
- Multiple arrows may be held at once; each output is independent.
- Reset asserted mid-frame abandons the frame immediately. The first frame after reset decodes normally.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: Readable pulses only when the addressed arrow output actually changes value. Typematic repeats (E0 75 sent repeatedly while held) produce no Readable.
- Undefined: Readable pulses on every accepted arrow make or break, repeats included. Output levels are identical in both builds.

Test Plan:
- Good frames E0 then 75 (parity bits 0, 0) -> ScanValid pulses twice with ScanCode E0 then 75; Up=1; Readable pulses once, 2 cycles after the stop fall.
- After that, send E0 F0 75 (F0 parity 1) -> Up=0 and Readable pulses once; Down/Left/Right remain 0 throughout.
- Frame 75 with parity bit 1 -> FrameError one pulse, no ScanValid, ScanCode unchanged; then E0 6B -> Left=1, proving the flags cleared.
- Start plus 5 data bits, then PS2Clk held high for TIMEOUT_CYCLES -> FrameError after exactly TIMEOUT_CYCLES-1 idle cycles; following E0 74 -> Right=1.
- Non-extended 72 -> ScanValid with ScanCode 72, Down stays 0, no Readable.
- With Up=1, send E0 75 a second time -> Readable pulses only when the macro is undefined. Then assert RST mid-frame -> all outputs 0 asynchronously, and the next E0 72 gives Down=1.
